// File: rtl/debounce_trig.sv
// -----------------------------------------------------------------------------
// debounce_trig
// Turns a raw, bouncy, asynchronous push-button into a clean synchronous
// trigger level plus one-cycle rise/fall strobes for the press detectors.
//
// The button is first brought into the clock domain by a two-flop
// synchronizer. It is then sampled once per prescaled tick. The level changes
// only after STABLE_CNT consecutive samples disagree with the current level.
//
// Parameters
//   SAMPLE_DIV  clk cycles per sample tick (>= 2)
//   STABLE_CNT  consecutive agreeing samples needed to change level (>= 2)
//
// Ports
//   clk          in   system clock, all logic on posedge
//   rst          in   synchronous active-high reset
//   btn_raw      in   asynchronous raw button, active-high, may bounce
//   trig_level   out  debounced level, 1 = pressed (registered)
//   trig_rise    out  one-cycle strobe on the 0->1 change of trig_level
//   trig_fall    out  one-cycle strobe on the 1->0 change of trig_level
//   sample_tick  out  one-cycle strobe marking each sample instant
// -----------------------------------------------------------------------------
module debounce_trig #(
    parameter int SAMPLE_DIV = 1000,
    parameter int STABLE_CNT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic trig_level,
    output logic trig_rise,
    output logic trig_fall,
    output logic sample_tick
);

    localparam int PW = $clog2(SAMPLE_DIV);
    localparam int SW = $clog2(STABLE_CNT + 1);

    localparam logic [PW-1:0] PRE_LAST = PW'(SAMPLE_DIV - 1);
    // The tick flop is loaded one cycle early so it is high exactly while
    // the prescaler count sits at its last value.
    localparam logic [PW-1:0] PRE_ARM  = PW'(SAMPLE_DIV - 2);
    localparam logic [PW-1:0] PRE_ZERO = PW'(0);
    localparam logic [PW-1:0] PRE_ONE  = PW'(1);

    localparam logic [SW-1:0] STAB_MAX  = SW'(STABLE_CNT);
    localparam logic [SW-1:0] STAB_ZERO = SW'(0);
    localparam logic [SW-1:0] STAB_ONE  = SW'(1);

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        ARM_PRESS   = 2'd1,
        PRESSED     = 2'd2,
        ARM_RELEASE = 2'd3
    } state_t;

    logic          btn_meta_r;
    logic          btn_sync_r;
    logic [PW-1:0] pre_cnt_r;
    logic          tick_r;
    state_t        state_r;
    state_t        state_next_s;
    logic [SW-1:0] stab_r;
    logic [SW-1:0] stab_next_s;
    logic [SW-1:0] stab_inc_s;
    logic          level_r;
    logic          rise_r;
    logic          fall_r;
    logic          level_next_s;
    logic          rise_next_s;
    logic          fall_next_s;

    // Two-flop synchronizer for the asynchronous button input
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_meta_r <= 1'b0;
            btn_sync_r <= 1'b0;
        end else begin
            btn_meta_r <= btn_raw;
            btn_sync_r <= btn_meta_r;
        end
    end

    // Free-running sample prescaler and its registered tick strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt_r <= PRE_ZERO;
            tick_r    <= 1'b0;
        end else begin
            if (pre_cnt_r == PRE_LAST) begin
                pre_cnt_r <= PRE_ZERO;
            end else begin
                pre_cnt_r <= pre_cnt_r + PRE_ONE;
            end
            tick_r <= (pre_cnt_r == PRE_ARM);
        end
    end

    // Saturating increment of the stability counter
    always_comb begin
        stab_inc_s = stab_r;
        if (stab_r == STAB_MAX) begin
            stab_inc_s = stab_r;
        end else begin
            stab_inc_s = stab_r + STAB_ONE;
        end
    end

    // Debounce FSM next-state logic, advanced only on sample ticks
    always_comb begin
        state_next_s = state_r;
        stab_next_s  = stab_r;
        if (tick_r) begin
            case (state_r)
                RELEASED: begin
                    if (btn_sync_r) begin
                        state_next_s = ARM_PRESS;
                        stab_next_s  = STAB_ONE;
                    end else begin
                        state_next_s = RELEASED;
                    end
                end
                ARM_PRESS: begin
                    if (btn_sync_r) begin
                        if (stab_inc_s == STAB_MAX) begin
                            state_next_s = PRESSED;
                            stab_next_s  = STAB_ZERO;
                        end else begin
                            stab_next_s  = stab_inc_s;
                        end
                    end else begin
                        // One disagreeing sample abandons the pending press.
                        state_next_s = RELEASED;
                        stab_next_s  = STAB_ZERO;
                    end
                end
                PRESSED: begin
                    if (!btn_sync_r) begin
                        state_next_s = ARM_RELEASE;
                        stab_next_s  = STAB_ONE;
                    end else begin
                        state_next_s = PRESSED;
                    end
                end
                ARM_RELEASE: begin
                    if (!btn_sync_r) begin
                        if (stab_inc_s == STAB_MAX) begin
                            state_next_s = RELEASED;
                            stab_next_s  = STAB_ZERO;
                        end else begin
                            stab_next_s  = stab_inc_s;
                        end
                    end else begin
                        state_next_s = PRESSED;
                        stab_next_s  = STAB_ZERO;
                    end
                end
                default: begin
                    state_next_s = RELEASED;
                    stab_next_s  = STAB_ZERO;
                end
            endcase
        end else begin
            state_next_s = state_r;
            stab_next_s  = stab_r;
        end
    end

    // Output decode from the next state so the registered outputs line up with the state
    always_comb begin
        level_next_s = (state_next_s == PRESSED) || (state_next_s == ARM_RELEASE);
        rise_next_s  = (state_r == ARM_PRESS)   && (state_next_s == PRESSED);
        fall_next_s  = (state_r == ARM_RELEASE) && (state_next_s == RELEASED);
    end

    // State, stability counter and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            // Reset drops straight to RELEASED with no fall strobe.
            state_r <= RELEASED;
            stab_r  <= STAB_ZERO;
            level_r <= 1'b0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            stab_r  <= stab_next_s;
            level_r <= level_next_s;
            rise_r  <= rise_next_s;
            fall_r  <= fall_next_s;
        end
    end

    assign trig_level  = level_r;
    assign trig_rise   = rise_r;
    assign trig_fall   = fall_r;
    assign sample_tick = tick_r;

endmodule

// File: tb/tb_debounce_trig.sv
// -----------------------------------------------------------------------------
// tb_debounce_trig
// Self-checking bench for debounce_trig with SAMPLE_DIV=4, STABLE_CNT=3.
// A reference model expresses debouncing as "the level flips once STABLE_CNT
// consecutive tick samples disagree with it". Each cycle it pushes the
// expected outputs into a queue, and the queue is popped against the DUT.
// A phase table holds the end-of-phase expectations: level, strobe counts
// and latency windows.
// -----------------------------------------------------------------------------
module tb_debounce_trig;

    localparam int DIV = 4;
    localparam int CNT = 3;
    localparam int NPH = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_raw = 1'b0;
    logic trig_level;
    logic trig_rise;
    logic trig_fall;
    logic sample_tick;

    always #5 clk = ~clk;

    debounce_trig #(
        .SAMPLE_DIV(DIV),
        .STABLE_CNT(CNT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .trig_level (trig_level),
        .trig_rise  (trig_rise),
        .trig_fall  (trig_fall),
        .sample_tick(sample_tick)
    );

    typedef struct {
        logic rst;
        logic base;
        int   period;   // 0 = constant input
        int   glen;     // cycles per period driven to ~base
        int   cycles;
        logic exp_level;
        int   exp_rises;
        int   exp_falls;
        int   lat_lo;
        int   lat_hi;   // 0 = no latency check
    } phase_t;

    phase_t ph [NPH];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rises_seen = 0;
    int falls_seen = 0;
    int last_rise_cyc = -1000;
    int release_cyc = 0;
    int first_tick_off = -1;

    // reference model state
    logic m_s1 = 1'b0;
    logic m_s2 = 1'b0;
    logic m_level = 1'b0;
    int   m_cnt = 0;
    int   m_run = 0;

    logic [3:0] exp_q [$];

    task automatic check_int(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: actual %0d, required %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Drive one clock cycle, advance the model, compare after the edge.
    task automatic step(input logic r, input logic raw);
        logic       tick_now;
        logic       smp;
        logic       rise;
        logic       fall;
        logic [3:0] exp_v;
        logic [3:0] act_v;
        rst     = r;
        btn_raw = raw;
        @(posedge clk);
        rise = 1'b0;
        fall = 1'b0;
        if (r) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_cnt = 0; m_level = 1'b0; m_run = 0;
        end else begin
            tick_now = (m_cnt == DIV - 1);
            smp      = m_s2;
            if (tick_now) begin
                if (smp != m_level) begin
                    m_run++;
                    if (m_run == CNT) begin
                        m_level = ~m_level;
                        rise    = m_level;
                        fall    = ~m_level;
                        m_run   = 0;
                    end
                end else begin
                    m_run = 0;
                end
            end
            m_cnt = (m_cnt + 1) % DIV;
            m_s2  = m_s1;
            m_s1  = raw;
        end
        exp_q.push_back({m_level, rise, fall, (!r && (m_cnt == DIV - 1))});
        #1;
        cyc++;
        act_v = {trig_level, trig_rise, trig_fall, sample_tick};
        exp_v = exp_q.pop_front();
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL cycle%0d {level,rise,fall,tick}: actual %b, required %b", cyc, act_v, exp_v);
        end
        if (r) begin
            release_cyc = cyc;
        end
        if (!r && sample_tick && first_tick_off < 0) begin
            first_tick_off = cyc - release_cyc;
        end
        if (trig_rise) begin
            rises_seen++;
            last_rise_cyc = cyc;
        end
        if (trig_fall) begin
            falls_seen++;
        end
    endtask

    initial begin
        int   start;
        logic raw;

        //          rst   base  per gl  cyc  lvl  r  f  lat_lo lat_hi
        ph[0]  = '{1'b1, 1'b1, 0,  0,  3,   1'b0, 0, 0, 0,  0};   // reset with button high
        ph[1]  = '{1'b0, 1'b0, 0,  0,  8,   1'b0, 0, 0, 0,  0};
        ph[2]  = '{1'b0, 1'b1, 0,  0,  40,  1'b1, 1, 0, 10, 15};  // steady press
        ph[3]  = '{1'b0, 1'b0, 0,  0,  8,   1'b1, 0, 0, 0,  0};   // low for 2 ticks only
        ph[4]  = '{1'b0, 1'b1, 0,  0,  12,  1'b1, 0, 0, 0,  0};   // back high: release aborted
        ph[5]  = '{1'b0, 1'b0, 0,  0,  20,  1'b0, 0, 1, 0,  0};   // real release
        ph[6]  = '{1'b0, 1'b0, 5,  1,  60,  1'b0, 0, 0, 0,  0};   // 1-cycle glitches every 5
        ph[7]  = '{1'b0, 1'b0, 8,  4,  100, 1'b0, 0, 0, 0,  0};   // toggle every tick
        ph[8]  = '{1'b0, 1'b1, 0,  0,  40,  1'b1, 1, 0, 0,  0};   // press again
        ph[9]  = '{1'b1, 1'b1, 0,  0,  1,   1'b0, 0, 0, 0,  0};   // reset while pressed
        ph[10] = '{1'b0, 1'b1, 0,  0,  40,  1'b1, 1, 0, 12, 12};  // debounced from scratch
        ph[11] = '{1'b0, 1'b0, 0,  0,  30,  1'b0, 0, 1, 0,  0};

        for (int p = 0; p < NPH; p++) begin
            start         = cyc;
            rises_seen    = 0;
            falls_seen    = 0;
            last_rise_cyc = -1000;
            for (int i = 0; i < ph[p].cycles; i++) begin
                raw = (ph[p].period > 0 && (i % ph[p].period) < ph[p].glen) ? ~ph[p].base : ph[p].base;
                step(ph[p].rst, raw);
            end
            check_int($sformatf("ph%0d_level", p), int'(trig_level), int'(ph[p].exp_level), int'(ph[p].exp_level));
            check_int($sformatf("ph%0d_rises", p), rises_seen, ph[p].exp_rises, ph[p].exp_rises);
            check_int($sformatf("ph%0d_falls", p), falls_seen, ph[p].exp_falls, ph[p].exp_falls);
            if (ph[p].lat_hi > 0) begin
                check_int($sformatf("ph%0d_rise_latency", p), last_rise_cyc - start, ph[p].lat_lo, ph[p].lat_hi);
            end
        end

        // The first tick after the first reset comes when the prescaler first reads DIV-1.
        check_int("first_tick_offset", first_tick_off, DIV - 1, DIV - 1);

        // Two-cycle pulse that falls wholly between two ticks is never seen.
        step(1'b1, 1'b0);
        rises_seen = 0;
        falls_seen = 0;
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, (i == 3 || i == 4) ? 1'b1 : 1'b0);
        end
        check_int("between_ticks_rises", rises_seen, 0, 0);
        check_int("between_ticks_level", int'(trig_level), 0, 0);

        // A press held through reset release rises exactly when the third tick sees it.
        step(1'b1, 1'b1);
        start         = cyc;
        rises_seen    = 0;
        last_rise_cyc = -1000;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1);
        end
        check_int("post_reset_rise_count", rises_seen, 1, 1);
        check_int("post_reset_rise_cycle", last_rise_cyc - start, 3 * DIV, 3 * DIV);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
